// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding and the IF/DE bundle layout.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_de_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_de_pipe_reg.sv
// IF/DE pipeline register with bubble > hold > load priority.
// A bubble keeps the last PC but drops the instruction to a NOP.
module if_de_pipe_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_INST
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bubble_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    if_de_t q_q;
    if_de_t q_d;

    // Select next IF/DE contents; anything not loaded or held is a bubble.
    always_comb begin
        q_d       = q_q;
        q_d.inst  = NOP_WORD;
        q_d.valid = 1'b0;
        if (bubble_i) begin
            q_d.inst  = NOP_WORD;
            q_d.valid = 1'b0;
        end else if (hold_i) begin
            q_d = q_q;
        end else if (load_i) begin
            q_d.pc    = pc_i;
            q_d.inst  = inst_i;
            q_d.valid = 1'b1;
        end
    end

    // Register the IF/DE bundle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q.pc    <= 32'h0;
            q_q.inst  <= NOP_WORD;
            q_q.valid <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign pc_o    = q_q.pc;
    assign inst_o  = q_q.inst;
    assign valid_o = q_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, imem handshake, IF/DE register.
// One request outstanding; DRAIN swallows the response of a squashed fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_de,
    output logic [31:0] inst_de,
    output logic        valid_de
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_inst_q, buf_inst_d;

    logic         req;
    logic         ld;
    logic [31:0]  ld_pc;
    logic [31:0]  ld_inst;
    logic [31:0]  tgt;
    logic [31:0]  pc_inc;

    assign tgt    = word_align(br_target);
    assign pc_inc = pc_q + 32'd4;

    // Next-state, PC update and IF/DE load selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        req        = 1'b0;
        ld         = 1'b0;
        ld_pc      = pc_q;
        ld_inst    = imem_rdata;
        unique case (state_q)
            ISSUE: begin
                if (br_taken) begin
                    pc_d = tgt;
                end else begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = ISSUE;
                    if (br_taken) begin
                        pc_d = tgt;
                    end else if (stall_if) begin
                        buf_pc_d   = pc_q;
                        buf_inst_d = imem_rdata;
                        pc_d       = pc_inc;
                        state_d    = HOLD;
                    end else begin
                        ld   = 1'b1;
                        pc_d = pc_inc;
                    end
                end else if (br_taken) begin
                    pc_d    = tgt;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (br_taken) begin
                    pc_d = tgt;
                end
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_d    = tgt;
                    state_d = ISSUE;
                end else if (!stall_if) begin
                    ld      = 1'b1;
                    ld_pc   = buf_pc_q;
                    ld_inst = buf_inst_q;
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // Fetch state, PC and hold buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ISSUE;
            pc_q       <= RESET_PC;
            buf_pc_q   <= 32'h0;
            buf_inst_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign imem_req  = req & rst;
    assign imem_addr = pc_q;

    if_de_pipe_reg #(
        .NOP_WORD (NOP_INST)
    ) u_if_de (
        .clk_i    (clk),
        .rst_ni   (rst),
        .bubble_i (br_taken),
        .hold_i   (stall_if),
        .load_i   (ld),
        .pc_i     (ld_pc),
        .inst_i   (ld_inst),
        .pc_o     (pc_de),
        .inst_o   (inst_de),
        .valid_o  (valid_de)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall, redirect, drain,
// reset mid-transaction and PC wrap, with hand-computed expectations.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_de;
    logic [31:0] inst_de;
    logic        valid_de;

    int n_chk = 0;
    int n_bad = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_if    (stall_if),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_de       (pc_de),
        .inst_de     (inst_de),
        .valid_de    (valid_de)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_de(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst, input logic v);
        chk({tag, ".pc"}, pc_de, pc);
        chk({tag, ".inst"}, inst_de, inst);
        chk({tag, ".valid"}, {31'b0, valid_de}, {31'b0, v});
    endtask

    task automatic chk_req(input string tag, input logic r,
                           input logic [31:0] a);
        chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, r});
        if (r) chk({tag, ".addr"}, imem_addr, a);
    endtask

    initial begin
        rst         = 1'b0;
        stall_if    = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        tick();
        tick();
        #1;
        chk_req("rst", 1'b0, 32'h0);
        chk("rst.addr", imem_addr, 32'h0);
        chk_de("rst", 32'h0, NOP, 1'b0);

        // 1: first fetch with 1-cycle memory
        rst = 1'b1;
        #1;
        chk_req("t1.issue", 1'b1, 32'h0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        #1;
        chk_req("t1.wait", 1'b0, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk_de("t1.de", 32'h0, 32'h0050_0093, 1'b1);
        chk_req("t1.next", 1'b1, 32'h4);

        // 2: stall for 3 cycles while response for PC 4 arrives
        tick();
        stall_if    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_8133;
        #1;
        chk("t2.bub.valid", {31'b0, valid_de}, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk_de("t2.s1", 32'h0, NOP, 1'b0);
        chk_req("t2.s1", 1'b0, 32'h0);
        tick();
        tick();
        stall_if = 1'b0;
        #1;
        chk_de("t2.s3", 32'h0, NOP, 1'b0);
        chk_req("t2.s3", 1'b0, 32'h0);
        tick();
        #1;
        chk_de("t2.rel", 32'h4, 32'h0020_8133, 1'b1);
        chk_req("t2.next", 1'b1, 32'h8);

        // 3: redirect during a 3-cycle access, stale data drained
        tick();
        #1;
        chk("t3.bub.valid", {31'b0, valid_de}, 32'h0);
        br_taken  = 1'b1;
        br_target = 32'h0000_0103;
        tick();
        br_taken = 1'b0;
        #1;
        chk_de("t3.redir", 32'h4, NOP, 1'b0);
        chk_req("t3.drain", 1'b0, 32'h0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk_req("t3.drain2", 1'b0, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk_de("t3.stale", 32'h4, NOP, 1'b0);
        chk_req("t3.next", 1'b1, 32'h100);

        // 4: branch and stall together while holding a buffered word
        tick();
        stall_if    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        br_taken    = 1'b1;
        br_target   = 32'h0000_0200;
        #1;
        chk_req("t4.hold", 1'b0, 32'h0);
        tick();
        br_taken = 1'b0;
        stall_if = 1'b0;
        #1;
        chk_de("t4.drop", 32'h4, NOP, 1'b0);
        chk_req("t4.next", 1'b1, 32'h200);

        // 5: reset mid-WAIT, late response ignored, restart at 0
        tick();
        rst         = 1'b0;
        #1;
        chk_de("t5.rst", 32'h0, NOP, 1'b0);
        chk_req("t5.rst", 1'b0, 32'h0);
        chk("t5.rst.addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        tick();
        rst = 1'b1;
        #1;
        chk_req("t5.issue", 1'b1, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk_de("t5.late", 32'h0, NOP, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_3333;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk_de("t5.fetch", 32'h0, 32'h3333_3333, 1'b1);
        chk_req("t5.next", 1'b1, 32'h4);

        // 6: redirect in ISSUE to top of memory, fetch wraps to 0
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFF;
        #1;
        chk_req("t6.br", 1'b0, 32'h0);
        tick();
        br_taken = 1'b0;
        #1;
        chk_req("t6.top", 1'b1, 32'hFFFF_FFFC);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4444_4444;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk_de("t6.de", 32'hFFFF_FFFC, 32'h4444_4444, 1'b1);
        chk_req("t6.wrap", 1'b1, 32'h0);

        // 7: response and branch in the same WAIT cycle
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        br_taken    = 1'b1;
        br_target   = 32'h0000_0040;
        tick();
        imem_rvalid = 1'b0;
        br_taken    = 1'b0;
        #1;
        chk_de("t7.drop", 32'hFFFF_FFFC, NOP, 1'b0);
        chk_req("t7.next", 1'b1, 32'h40);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
